// File: rtl/uart_frame_pkg.sv
// Framing constants shared by the score/ID frame transmitter and receiver.
// Frame: SYNC, ID, BCD[23:16], BCD[15:8], BCD[7:0], CHK (CHK = ID^B2^B1^B0).
package uart_frame_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned FRAME_LEN = 6;

  localparam int unsigned POS_SYNC = 0;
  localparam int unsigned POS_ID   = 1;
  localparam int unsigned POS_B2   = 2;
  localparam int unsigned POS_B1   = 3;
  localparam int unsigned POS_B0   = 4;
  localparam int unsigned POS_CHK  = FRAME_LEN - 1;

  // Each state names the frame position of the byte it is waiting for.
  typedef enum logic [2:0] {
    ST_HUNT = 3'(POS_SYNC),
    ST_ID   = 3'(POS_ID),
    ST_B2   = 3'(POS_B2),
    ST_B1   = 3'(POS_B1),
    ST_B0   = 3'(POS_B0),
    ST_CHK  = 3'(POS_CHK)
  } frame_state_t;

endpackage

// File: rtl/uart_frame_rx_timeout.sv
// Saturating cycle counter; expired stays high once LIMIT-1 is reached until cleared.
module timeout_counter #(
  parameter int unsigned LIMIT = 75_000,
  parameter int unsigned W     = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Pops a UART rx FIFO, decodes SYNC/ID/BCD/CHK score frames and publishes
// the remote board's {BCD points, board_ID} word with link supervision.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 75_000,
  parameter int unsigned LINK_TIMEOUT = 75_000_000,
  parameter int unsigned TO_W         = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rd_en,
  output logic [31:0] ext_data,
  output logic        ext_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        link_up
);

  frame_state_t state, state_nx;
  logic [7:0]   id_q, b2_q, b1_q, b0_q, xor_q;
  logic         accept, in_frame;
  logic         chk_good, chk_bad, byte_to, link_drop;
  logic         byte_expired, link_expired;

  timeout_counter #(.LIMIT(BYTE_TIMEOUT), .W(TO_W)) u_byte_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept | ~in_frame),
    .en      (in_frame),
    .expired (byte_expired)
  );

  timeout_counter #(.LIMIT(LINK_TIMEOUT), .W(TO_W)) u_link_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (chk_good),
    .en      (1'b1),
    .expired (link_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (accept) begin
      case (state)
        ST_HUNT: if (rx_data == SYNC_BYTE) state_nx = ST_ID;
        ST_ID:   state_nx = ST_B2;
        ST_B2:   state_nx = ST_B1;
        ST_B1:   state_nx = ST_B0;
        ST_B0:   state_nx = ST_CHK;
        default: state_nx = ST_HUNT;
      endcase
    end else if (byte_to) begin
      state_nx = ST_HUNT;
    end
  end

  // An accepted byte always beats a timeout that expires in the same cycle.
  always_comb begin
    rd_en     = ~rx_empty;
    accept    = ~rx_empty;
    in_frame  = (state != ST_HUNT);
    chk_good  = accept && (state == ST_CHK) && (rx_data == xor_q);
    chk_bad   = accept && (state == ST_CHK) && (rx_data != xor_q);
    byte_to   = in_frame && !accept && byte_expired;
    link_drop = link_up && link_expired && !chk_good;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= '0;
      b2_q      <= '0;
      b1_q      <= '0;
      b0_q      <= '0;
      xor_q     <= '0;
      ext_data  <= '0;
      ext_valid <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      link_up   <= 1'b0;
    end else begin
      if (accept) begin
        case (state)
          ST_ID:   begin id_q <= rx_data; xor_q <= rx_data;         end
          ST_B2:   begin b2_q <= rx_data; xor_q <= xor_q ^ rx_data; end
          ST_B1:   begin b1_q <= rx_data; xor_q <= xor_q ^ rx_data; end
          ST_B0:   begin b0_q <= rx_data; xor_q <= xor_q ^ rx_data; end
          default: ;
        endcase
      end

      ext_valid <= chk_good;
      frame_err <= chk_bad | byte_to;

      // A dropped link reads as ext_data == 0 so the slot appears free downstream.
      if (chk_good) begin
        ext_data <= {b2_q, b1_q, b0_q, id_q};
        link_up  <= 1'b1;
      end else if (link_drop) begin
        ext_data <= '0;
        link_up  <= 1'b0;
      end

      if ((chk_bad || byte_to) && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: directed scenarios plus a random byte
// stream, all compared against a queue-based frame parser model.
module tb_uart_frame_rx;

  localparam int unsigned BT   = 20;
  localparam int unsigned LT   = 400;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rd_en;
  logic [31:0] ext_data;
  logic        ext_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        link_up;

  int unsigned tests = 0;
  int unsigned fails = 0;

  uart_frame_rx #(.BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT), .TO_W(27)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_empty  (rx_empty),
    .rx_data   (rx_data),
    .rd_en     (rd_en),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .link_up   (link_up)
  );

  always #5 clk = ~clk;

  // Reference: collect bytes from a SYNC into a 6-byte buffer, judge the whole frame.
  logic [7:0]  fbuf[$];
  int unsigned m_gap, m_k;
  logic        m_valid, m_err, m_link;
  logic [7:0]  m_cnt;
  logic [31:0] m_data;
  logic [42:0] obs, exp_vec;
  logic [8:0]  ev[$];

  assign obs     = {ext_valid, frame_err, link_up, err_cnt, ext_data};
  assign exp_vec = {m_valid, m_err, m_link, m_cnt, m_data};

  task automatic model_reset();
    fbuf.delete();
    m_gap = 0; m_k = 0;
    m_valid = 1'b0; m_err = 1'b0; m_link = 1'b0;
    m_cnt = 8'h00; m_data = 32'h0;
  endtask

  task automatic model_step(input bit have, input logic [7:0] b);
    bit good;
    good = 1'b0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_k++;
    if (have) begin
      m_gap = 0;
      if (fbuf.size() != 0 || b == SYNC) fbuf.push_back(b);
      if (fbuf.size() == 6) begin
        if ((fbuf[1] ^ fbuf[2] ^ fbuf[3] ^ fbuf[4]) == fbuf[5]) begin
          good = 1'b1; m_valid = 1'b1; m_link = 1'b1; m_k = 0;
          m_data = {fbuf[2], fbuf[3], fbuf[4], fbuf[1]};
        end else begin
          m_err = 1'b1;
          if (m_cnt != 8'hFF) m_cnt++;
        end
        fbuf.delete();
      end
    end else if (fbuf.size() != 0) begin
      m_gap++;
      if (m_gap >= BT) begin
        fbuf.delete(); m_gap = 0; m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt++;
      end
    end
    if (!good && m_link && m_k >= LT) begin
      m_link = 1'b0;
      m_data = 32'h0;
    end
  endtask

  task automatic step(input bit have, input logic [7:0] b);
    rx_empty = ~have;
    rx_data  = have ? b : 8'h00;
    model_step(have, b);
    @(posedge clk);
    #1;
  endtask

  task automatic add_byte(input logic [7:0] b);
    ev.push_back({1'b1, b});
  endtask

  task automatic add_idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) ev.push_back(9'h000);
  endtask

  task automatic add_frame(input logic [7:0] id, b2, b1, b0, chk);
    add_byte(SYNC); add_byte(id); add_byte(b2); add_byte(b1); add_byte(b0); add_byte(chk);
  endtask

  function automatic int unsigned gap_pick();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r == 0) return BT;
    if (r == 1) return BT - 1;
    return $urandom_range(0, 2);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs !== 43'h0) begin
      fails++; $display("FAIL reset_outputs: got %h want %h", obs, 43'h0);
    end
    rx_empty = 1'b0; #1;
    tests++;
    if (rd_en !== 1'b1) begin fails++; $display("FAIL rd_en_high: got %b want 1", rd_en); end
    rx_empty = 1'b1; #1;
    tests++;
    if (rd_en !== 1'b0) begin fails++; $display("FAIL rd_en_low: got %b want 0", rd_en); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_good_frame();
    ev.delete();
    add_frame(8'h07, 8'h00, 8'h12, 8'h34, 8'h21);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL good_frame step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({ext_valid, ext_data, link_up, err_cnt} !== {1'b1, 32'h00123407, 1'b1, 8'h00}) begin
      fails++; $display("FAIL good_frame_result: got v=%b d=%h l=%b e=%h want v=1 d=00123407 l=1 e=00",
                        ext_valid, ext_data, link_up, err_cnt);
    end
    step(1'b0, 8'h00);
    tests++;
    if (ext_valid !== 1'b0) begin fails++; $display("FAIL good_frame_pulse: got %b want 0", ext_valid); end
  endtask

  task automatic test_garbage_prefix();
    bit seen_err;
    seen_err = 1'b0;
    ev.delete();
    add_byte(8'h3C); add_byte(8'hFF);
    add_frame(8'h07, 8'h00, 8'h12, 8'h34, 8'h21);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      seen_err |= frame_err;
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL garbage_prefix step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({seen_err, ext_valid, ext_data} !== {1'b0, 1'b1, 32'h00123407}) begin
      fails++; $display("FAIL garbage_prefix_result: got err=%b v=%b d=%h want err=0 v=1 d=00123407",
                        seen_err, ext_valid, ext_data);
    end
  endtask

  task automatic test_bad_checksum();
    ev.delete();
    add_frame(8'h07, 8'h00, 8'h12, 8'h34, 8'h20);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL bad_checksum step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({frame_err, ext_valid, err_cnt, ext_data} !== {1'b1, 1'b0, 8'h01, 32'h00123407}) begin
      fails++; $display("FAIL bad_checksum_result: got fe=%b v=%b e=%h d=%h want fe=1 v=0 e=01 d=00123407",
                        frame_err, ext_valid, err_cnt, ext_data);
    end
    ev.delete();
    add_frame(8'h09, 8'h98, 8'h76, 8'h54, 8'hB3);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL recover_frame step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({ext_valid, ext_data} !== {1'b1, 32'h98765409}) begin
      fails++; $display("FAIL recover_frame_result: got v=%b d=%h want v=1 d=98765409", ext_valid, ext_data);
    end
  endtask

  task automatic test_byte_timeout();
    bit seen_err;
    ev.delete();
    add_byte(SYNC); add_byte(8'h07); add_idle(BT);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL byte_timeout step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({frame_err, err_cnt} !== {1'b1, 8'h02}) begin
      fails++; $display("FAIL byte_timeout_result: got fe=%b e=%h want fe=1 e=02", frame_err, err_cnt);
    end
    seen_err = 1'b0;
    ev.delete();
    add_byte(SYNC); add_byte(8'h07); add_idle(BT - 1);
    add_byte(8'h00); add_byte(8'h12); add_byte(8'h34); add_byte(8'h21);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      seen_err |= frame_err;
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL timeout_edge step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({seen_err, ext_valid, ext_data, err_cnt} !== {1'b0, 1'b1, 32'h00123407, 8'h02}) begin
      fails++; $display("FAIL timeout_edge_result: got err=%b v=%b d=%h e=%h want err=0 v=1 d=00123407 e=02",
                        seen_err, ext_valid, ext_data, err_cnt);
    end
  endtask

  task automatic test_link_loss();
    ev.delete();
    add_frame(8'h07, 8'h00, 8'h12, 8'h34, 8'h21);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL link_frame step %0d: got %h want %h", i, obs, exp_vec); end
    end
    for (int unsigned i = 1; i <= LT + 3; i++) begin
      step(1'b0, 8'h00);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL link_idle step %0d: got %h want %h", i, obs, exp_vec); end
      if (i == LT - 1) begin
        tests++;
        if (link_up !== 1'b1) begin fails++; $display("FAIL link_before_limit: got %b want 1", link_up); end
      end
      if (i == LT) begin
        tests++;
        if ({link_up, ext_data, ext_valid} !== {1'b0, 32'h0, 1'b0}) begin
          fails++; $display("FAIL link_drop: got l=%b d=%h v=%b want l=0 d=00000000 v=0", link_up, ext_data, ext_valid);
        end
      end
    end
    ev.delete();
    add_frame(8'h09, 8'h98, 8'h76, 8'h54, 8'hB3);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL link_restore step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({link_up, ext_data} !== {1'b1, 32'h98765409}) begin
      fails++; $display("FAIL link_restore_result: got l=%b d=%h want l=1 d=98765409", link_up, ext_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] fb [6];
    ev.delete();
    while (ev.size() < 3000) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r <= 1) begin
        add_byte(8'($urandom_range(0, 255)) ^ ((r == 0) ? 8'h00 : 8'h5A));
      end else if (r <= 15) begin
        fb[0] = SYNC;
        for (int k = 1; k < 5; k++) fb[k] = ($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom);
        fb[5] = fb[1] ^ fb[2] ^ fb[3] ^ fb[4];
        if (r >= 14) fb[5] = fb[5] ^ 8'($urandom_range(1, 255));
        for (int k = 0; k < 6; k++) begin
          if (k > 0) add_idle(gap_pick());
          add_byte(fb[k]);
        end
      end else if (r <= 17) begin
        add_idle($urandom_range(1, 40));
      end else if (r == 18) begin
        add_idle(LT + 2);
      end else begin
        add_byte(SYNC);
      end
    end
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL random step %0d: got %h want %h", i, obs, exp_vec); end
    end
  endtask

  task automatic test_saturation();
    ev.delete();
    for (int unsigned n = 0; n < 300; n++) add_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL saturation step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if (err_cnt !== 8'hFF) begin fails++; $display("FAIL saturation_result: got %h want ff", err_cnt); end
  endtask

  task automatic test_async_reset();
    ev.delete();
    add_frame(8'h09, 8'h98, 8'h76, 8'h54, 8'hB3);
    add_byte(SYNC); add_byte(8'h07); add_byte(8'h00);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL pre_reset step %0d: got %h want %h", i, obs, exp_vec); end
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if (obs !== 43'h0) begin fails++; $display("FAIL async_reset: got %h want %h", obs, 43'h0); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    ev.delete();
    add_byte(8'h12); add_byte(8'h34); add_byte(8'h21);
    add_frame(8'h07, 8'h00, 8'h12, 8'h34, 8'h21);
    foreach (ev[i]) begin
      step(ev[i][8], ev[i][7:0]);
      tests++;
      if (obs !== exp_vec) begin fails++; $display("FAIL post_reset step %0d: got %h want %h", i, obs, exp_vec); end
    end
    tests++;
    if ({ext_valid, ext_data, err_cnt} !== {1'b1, 32'h00123407, 8'h00}) begin
      fails++; $display("FAIL post_reset_result: got v=%b d=%h e=%h want v=1 d=00123407 e=00",
                        ext_valid, ext_data, err_cnt);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_good_frame();
    test_garbage_prefix();
    test_bad_checksum();
    test_byte_timeout();
    test_link_loss();
    test_random();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
